fa_pipe: RTL and testbench

Parametrised, pipelined ripple adder/subtractor for the Jaguar datapath netlists. It generalises the fixed 4-bit full-adder cell to WIDTH bits split into SEG-bit segments, with one segment resolved per pipeline stage and the carry registered between stages. A valid/ready handshake on both sides carries backpressure, so the block can sit between blitter or GPU datapath stages that stall.

---
 rtl/fa_pipe.sv | 151 +++++++++++++++
 tb/tb_fa_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_pipe.sv
// fa_pipe -- pipelined WIDTH-bit adder/subtractor.
// One SEG-bit segment is resolved per stage and the carry is registered between
// stages. Valid/ready handshakes on both sides carry backpressure.
// Optional build macro: FA_PIPE_FLAGS_EN adds registered ov (signed overflow)
// and z (sum is zero) outputs. The default build has neither port nor logic.
// WIDTH must be a multiple of SEG, with STAGES = WIDTH/SEG >= 1.
module fa_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef FA_PIPE_FLAGS_EN
  ,
  output logic             ov,
  output logic             z
`endif
);

  localparam int STAGES = WIDTH / SEG;

  // Effective addend: b inverted for subtraction.
  logic [WIDTH-1:0]  w_eb;

  // Per-stage state exported from each stage scope so that the next stage
  // and the advance chain can see it.
  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_cy;
  logic [STAGES-1:0] w_adv;
  logic [WIDTH-1:0]  w_sa [STAGES];
  logic [WIDTH-1:0]  w_b  [STAGES];

  assign w_eb = b ^ {WIDTH{sub}};

  // Advance chain, resolved from the output end back to the input end.
  // A stage may load when it is empty or when its own content moves on.
  // This path is purely combinational from out_ready to in_ready.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_vld[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !w_vld[k] || w_adv[k+1];
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_vld[STAGES-1];
  assign s         = w_sa[STAGES-1];
  assign co        = w_cy[STAGES-1];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
      // Bit offset of the segment this stage resolves.
      localparam int LO = gi * SEG;

      logic             w_in_vld;
      logic             w_in_cy;
      logic [WIDTH-1:0] w_in_sa;
      logic [WIDTH-1:0] w_in_b;
      logic [SEG:0]     w_seg;
      logic [WIDTH-1:0] w_sa_next;

      // r_sa packs the resolved sum segments in its low bits and the still
      // unresolved augend segments in its high bits. Each stage overwrites
      // exactly one augend segment with its sum segment, so after the last
      // stage r_sa is the complete sum. r_b carries the effective addend;
      // its already-consumed low segments are dead and trimmed by synthesis.
      logic             r_vld;
      logic             r_cy;
      logic [WIDTH-1:0] r_sa;
      logic [WIDTH-1:0] r_b;

      if (gi == 0) begin : gen_head
        assign w_in_vld = in_valid;
        assign w_in_cy  = ci;
        assign w_in_sa  = a;
        assign w_in_b   = w_eb;
      end else begin : gen_body
        assign w_in_vld = w_vld[gi-1];
        assign w_in_cy  = w_cy[gi-1];
        assign w_in_sa  = w_sa[gi-1];
        assign w_in_b   = w_b[gi-1];
      end

      // Segment add: SEG sum bits plus the carry handed to the next stage.
      assign w_seg = {1'b0, w_in_sa[LO +: SEG]}
                   + {1'b0, w_in_b[LO +: SEG]}
                   + {{SEG{1'b0}}, w_in_cy};

      // Splice this stage's sum segment over the augend segment it consumed.
      always_comb begin
        w_sa_next = w_in_sa;
        w_sa_next[LO +: SEG] = w_seg[SEG-1:0];
      end

      // Stage register: load from upstream on advance, otherwise hold.
      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_sa  <= '0;
          r_b   <= '0;
        end else if (w_adv[gi]) begin
          r_vld <= w_in_vld;
          r_cy  <= w_seg[SEG];
          r_sa  <= w_sa_next;
          r_b   <= w_in_b;
        end
      end

      assign w_vld[gi] = r_vld;
      assign w_cy[gi]  = r_cy;
      assign w_sa[gi]  = r_sa;
      assign w_b[gi]   = r_b;

`ifdef FA_PIPE_FLAGS_EN
      if (gi == STAGES - 1) begin : gen_flags
        logic r_ov;
        logic r_z;

        // Flags registered alongside the final sum. The carry into the MSB is
        // recovered as a ^ b ^ s at that bit; XOR with carry-out gives signed
        // overflow.
        always_ff @(posedge sys_clk or posedge reset) begin
          if (reset) begin
            r_ov <= 1'b0;
            r_z  <= 1'b0;
          end else if (w_adv[gi]) begin
            r_ov <= w_in_sa[WIDTH-1] ^ w_in_b[WIDTH-1] ^ w_seg[SEG-1] ^ w_seg[SEG];
            r_z  <= (w_sa_next == '0);
          end
        end

        assign ov = r_ov;
        assign z  = r_z;
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_fa_pipe.sv
// tb_fa_pipe -- directed and random checks of fa_pipe.
// u_dut is the default 16/4 build and has four stages. u_dut1 is the 16/16 build and has one stage.
// Expected results come from an arithmetic model plus a FIFO of accepted sets.
module tb_fa_pipe;
  localparam int W = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic         reset;
  logic         in_valid, in_ready, ci, sub, out_valid, out_ready, co;
  logic [W-1:0] a, b, s;
  logic         in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, co1;
  logic [W-1:0] a1, b1, s1;
`ifdef FA_PIPE_FLAGS_EN
  logic         ov, z, ov1, z1;
`endif

  fa_pipe #(.WIDTH(W), .SEG(4)) u_dut (
    .sys_clk(sys_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
`ifdef FA_PIPE_FLAGS_EN
    , .ov(ov), .z(z)
`endif
  );

  fa_pipe #(.WIDTH(W), .SEG(16)) u_dut1 (
    .sys_clk(sys_clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .co(co1)
`ifdef FA_PIPE_FLAGS_EN
    , .ov(ov1), .z(z1)
`endif
  );

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  res_t q0[$];
  int   checks = 0;
  int   errors = 0;

  // Plain arithmetic model. {co,s} is a + (b or ~b) + ci. ov is true when the signed sum is out of range.
  function automatic res_t model(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic cc, input logic ss);
    res_t        r;
    logic [15:0] eb;
    int unsigned tot;
    int          sgn;
    eb   = ss ? ~bb : bb;
    tot  = int'(aa) + int'(eb) + int'(cc);
    sgn  = int'($signed(aa)) + int'($signed(eb)) + int'(cc);
    r.s  = tot[15:0];
    r.co = tot[16];
    r.ov = (sgn > 32767) || (sgn < -32768);
    r.z  = (tot[15:0] == 16'h0000);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle of u_dut. Handshakes are sampled on the falling edge. Emitted results are checked against the FIFO head.
  // Inputs are then applied 1ns after the next rising edge.
  task automatic step(output bit acc, output bit emit);
    res_t e;
    @(negedge sys_clk);
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      if (q0.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'(0));
      end else begin
        e = q0.pop_front();
        $display("OUT s=0x%04h co=%0b expected s=0x%04h co=%0b", s, co, e.s, e.co);
        check("sb_s", 32'(s), 32'(e.s));
        check("sb_co", 32'(co), 32'(e.co));
`ifdef FA_PIPE_FLAGS_EN
        check("sb_ov", 32'(ov), 32'(e.ov));
        check("sb_z", 32'(z), 32'(e.z));
`endif
      end
    end
    if (acc) q0.push_back(model(a, b, ci, sub));
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    bit acc, emit;
    int n;
    n = 0;
    while (q0.size() != 0 && n < 40) begin
      step(acc, emit);
      n++;
    end
    check("drain_empty", 32'(q0.size()), 32'(0));
  endtask

  // Send a single set with out_ready=1. Wait for it to appear at the output, then check the latency and the constants.
  // The result is left on the output. The caller's next step() consumes it.
  task automatic one(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                     input logic cc, input logic ss, input logic [15:0] es, input logic eco);
    bit acc, emit;
    int n;
    a = aa; b = bb; ci = cc; sub = ss; in_valid = 1'b1;
    step(acc, emit);
    in_valid = 1'b0;
    check({tag, "_acc"}, 32'(acc), 32'(1));
    n = 0;
    while (!out_valid && n < 20) begin
      step(acc, emit);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(3));
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_co"}, 32'(co), 32'(eco));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit   acc, emit;
    int   idx, nemit;
    res_t e1;

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_s", 32'(s), 32'(0));
    check("rst_co", 32'(co), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid1", 32'(out_valid1), 32'(0));
    check("rst_s1", 32'(s1), 32'(0));
`ifdef FA_PIPE_FLAGS_EN
    check("rst_ov", 32'(ov), 32'(0));
    check("rst_z", 32'(z), 32'(0));
`endif

    // Wrap to zero. The latency is checked inside one().
    one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
`ifdef FA_PIPE_FLAGS_EN
    check("wrap_z", 32'(z), 32'(1));
    check("wrap_ov", 32'(ov), 32'(0));
`endif
    step(acc, emit);

    // Subtraction, without a borrow and then with a borrow.
    one("sub_nb", 16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1);
    step(acc, emit);
    one("sub_bw", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    step(acc, emit);

    // Signed overflow.
    one("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
`ifdef FA_PIPE_FLAGS_EN
    check("ovf_ov", 32'(ov), 32'(1));
    check("ovf_z", 32'(z), 32'(0));
`endif
    step(acc, emit);

    // Backpressure. Six sets, each with sum i+1, while the output stalls for 8 cycles.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6); a = 16'(idx); b = 16'h0001; ci = 1'b0; sub = 1'b0;
      step(acc, emit);
      if (acc) idx++;
    end
    check("bp_held", 32'(idx), 32'(4));
    check("bp_in_ready", 32'(in_ready), 32'(0));
    check("bp_out_valid", 32'(out_valid), 32'(1));
    check("bp_head_stable", 32'(s), 32'(1));
    out_ready = 1'b1;
    #1;
    check("bp_accept_while_full", 32'(in_ready), 32'(1));
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 6); a = 16'(idx); b = 16'h0001; ci = 1'b0; sub = 1'b0;
      check("bp_order", 32'(s), 32'(c + 1));
      step(acc, emit);
      if (acc) idx++;
      check("bp_one_per_cycle", 32'(emit), 32'(1));
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(idx), 32'(6));
    check("bp_none_left", 32'(q0.size()), 32'(0));

    // Back-to-back random sets with no stalls.
    nemit = 0;
    for (int c = 0; c < 20; c++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      check("b2b_in_ready", 32'(in_ready), 32'(1));
      step(acc, emit);
      if (emit) nemit++;
    end
    in_valid = 1'b0;
    check("b2b_emits", 32'(nemit), 32'(16));
    drain();

    // Single-stage build. The result is registered after one edge.
    check("s1_pre_valid", 32'(out_valid1), 32'(0));
    for (int c = 0; c < 6; c++) begin
      a1 = 16'($urandom); b1 = 16'($urandom); ci1 = 1'($urandom); sub1 = 1'($urandom);
      in_valid1 = 1'b1;
      e1 = model(a1, b1, ci1, sub1);
      check("s1_in_ready", 32'(in_ready1), 32'(1));
      @(posedge sys_clk);
      #1;
      $display("OUT1 s=0x%04h co=%0b expected s=0x%04h co=%0b", s1, co1, e1.s, e1.co);
      check("s1_valid", 32'(out_valid1), 32'(1));
      check("s1_s", 32'(s1), 32'(e1.s));
      check("s1_co", 32'(co1), 32'(e1.co));
`ifdef FA_PIPE_FLAGS_EN
      check("s1_ov", 32'(ov1), 32'(e1.ov));
      check("s1_z", 32'(z1), 32'(e1.z));
`endif
    end
    in_valid1 = 1'b0;
    @(posedge sys_clk);
    #1;
    check("s1_idle", 32'(out_valid1), 32'(0));

    // Reset while three sets are in flight in u_dut and one set is held in u_dut1.
    out_ready = 1'b0;
    out_ready1 = 1'b0;
    a1 = 16'h00F0; b1 = 16'h000F; ci1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a = 16'h1111 * 16'(c + 1); b = 16'h2222; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step(acc, emit);
      in_valid1 = 1'b0;
    end
    in_valid = 1'b0;
    step(acc, emit);
    step(acc, emit);
    check("rs_pre_valid", 32'(out_valid), 32'(1));
    check("rs_pre_s", 32'(s), 32'(16'h3333));
    check("rs_pre_s1", 32'(s1), 32'(16'h00FF));
    #2 reset = 1'b1;
    #1;
    check("rs_out_valid", 32'(out_valid), 32'(0));
    check("rs_s", 32'(s), 32'(0));
    check("rs_co", 32'(co), 32'(0));
    check("rs_in_ready", 32'(in_ready), 32'(1));
    check("rs_out_valid1", 32'(out_valid1), 32'(0));
    check("rs_s1", 32'(s1), 32'(0));
    q0.delete();
    @(posedge sys_clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    out_ready1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(acc, emit);
      check("rs_no_stale", 32'(out_valid), 32'(0));
      check("rs_no_stale1", 32'(out_valid1), 32'(0));
    end
    one("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);
    step(acc, emit);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
